sha256_digest_serializer: RTL

//  Read-out side of the SHA-256 core's wide result registers. Captures the 256-bit

---
 rtl/sha256_digest_serializer.sv | 102 ++++++++++
 1 files changed

// File: rtl/sha256_digest_serializer.sv
// Captures a wide SHA-256 digest on a load pulse and streams it out as OUT_W words,
// H0 first, over a valid/ready handshake. Every output comes straight from a flop.
module sha256_digest_serializer #(
  parameter  int DIGEST_W = 256,
  parameter  int OUT_W    = 64,
  localparam int NWORDS   = DIGEST_W / OUT_W,
  localparam int IDX_W    = $clog2(NWORDS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [DIGEST_W-1:0] digest_i,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  if (NWORDS < 2 || (DIGEST_W % OUT_W) != 0) begin : g_param_chk
    $error("DIGEST_W must be a multiple of OUT_W with at least two words");
  end

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  // Packed so element NWORDS-1 holds the most-significant word (word 0).
  logic [NWORDS-1:0][OUT_W-1:0] cap;
  logic [OUT_W-1:0]             words [NWORDS];
  logic [IDX_W-1:0]             idx_inc;
  logic [OUT_W-1:0]             word_inc;
  logic [OUT_W-1:0]             head;

  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    assign words[k] = cap[NWORDS-1-k];
  end

  // Output word is registered, so the next word is looked up one index ahead.
  always_comb begin
    idx_inc  = out_idx + IDX_W'(1);
    word_inc = words[idx_inc];
    head     = digest_i[DIGEST_W-1 -: OUT_W];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cap       <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= SEND;
            cap       <= digest_i;
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_data  <= head;
            out_last  <= 1'b0;
            busy_o    <= 1'b1;
          end
        end
        SEND: begin
          // A load is only taken together with the final transfer; otherwise dropped.
          if (load && !(out_ready && out_last))
            overrun_o <= 1'b1;
          if (out_ready) begin
            if (!out_last) begin
              out_idx  <= idx_inc;
              out_data <= word_inc;
              out_last <= (idx_inc == LAST_IDX);
            end else if (load) begin
              cap      <= digest_i;
              out_idx  <= '0;
              out_data <= head;
              out_last <= 1'b0;
            end else begin
              state     <= IDLE;
              out_idx   <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              busy_o    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
